// File: rtl/stage_exec.sv
// Execute stage of the in-order RV32I pipeline: operand select, ALU, jump/branch
// target and link generation, registered into a single payload for the memory stage.
module stage_exec #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_op1,
    input  logic [31:0] ex_op2,
    input  logic [31:0] ex_imm,
    input  logic        ex_op1_pc,
    input  logic        ex_op2_imm,
    input  logic [3:0]  ex_alu_op,
    input  logic        ex_read,
    input  logic        ex_write,
    input  logic        ex_extend,
    input  logic [1:0]  ex_width,
    input  logic        ex_jmp,
    input  logic        ex_jalr,
    input  logic        ex_br,
    input  logic        ex_br_inv,
    input  logic [4:0]  ex_reg,
    input  logic        ex_flush,
    input  logic        mem_stall,

    output logic        ex_stall,
    output logic        mem_valid,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_data0,
    output logic [31:0] mem_data1,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_extend,
    output logic [1:0]  mem_width,
    output logic        mem_jmp,
    output logic        mem_br,
    output logic        mem_br_inv,
    output logic [4:0]  wb_reg
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_SEQ  = 4'd10;

    function automatic logic [31:0] alu_f(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [4:0]         sh;
        sa = a;
        sb = b;
        sh = b[4:0];
        case (op)
            ALU_ADD:  alu_f = a + b;
            ALU_SUB:  alu_f = a - b;
            ALU_SLL:  alu_f = a << sh;
            ALU_SLT:  alu_f = {31'd0, (sa < sb)};
            ALU_SLTU: alu_f = {31'd0, (a < b)};
            ALU_XOR:  alu_f = a ^ b;
            ALU_SRL:  alu_f = a >> sh;
            ALU_SRA:  alu_f = sa >>> sh;
            ALU_OR:   alu_f = a | b;
            ALU_AND:  alu_f = a & b;
            ALU_SEQ:  alu_f = {31'd0, (a == b)};
            default:  alu_f = b;
        endcase
    endfunction

    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] alu_res;
    logic [31:0] jalr_sum;
    logic [31:0] tgt;
    logic [31:0] data0_d;
    logic [31:0] data1_d;
    logic        valid_d;

    logic        mem_valid_q;
    logic [31:0] mem_pc_q;
    logic [31:0] mem_data0_q;
    logic [31:0] mem_data1_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        mem_extend_q;
    logic [1:0]  mem_width_q;
    logic        mem_jmp_q;
    logic        mem_br_q;
    logic        mem_br_inv_q;
    logic [4:0]  wb_reg_q;

    always_comb begin
        opa      = ex_op1_pc  ? ex_pc  : ex_op1;
        opb      = ex_op2_imm ? ex_imm : ex_op2;
        alu_res  = alu_f(ex_alu_op, opa, opb);
        jalr_sum = ex_op1 + ex_imm;
        // Branches always use the pc-relative target; only JALR takes rs1.
        if (ex_jmp && ex_jalr) begin
            tgt = {jalr_sum[31:1], 1'b0};
        end else begin
            tgt = ex_pc + ex_imm;
        end
        data0_d  = ex_jmp ? (ex_pc + 32'd4) : alu_res;
        data1_d  = (ex_jmp || ex_br) ? tgt : ex_op2;
        valid_d  = ex_valid & ~ex_flush;
    end

    assign ex_stall = ex_valid & mem_stall;

    // Execute -> memory pipeline register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_valid_q  <= 1'b0;
            mem_pc_q     <= RESET_PC;
            mem_data0_q  <= 32'd0;
            mem_data1_q  <= 32'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_extend_q <= 1'b0;
            mem_width_q  <= 2'd0;
            mem_jmp_q    <= 1'b0;
            mem_br_q     <= 1'b0;
            mem_br_inv_q <= 1'b0;
            wb_reg_q     <= 5'd0;
        end else if (!mem_stall) begin
            mem_valid_q  <= valid_d;
            mem_pc_q     <= ex_pc;
            mem_data0_q  <= data0_d;
            mem_data1_q  <= data1_d;
            mem_read_q   <= ex_read;
            mem_write_q  <= ex_write;
            mem_extend_q <= ex_extend;
            mem_width_q  <= ex_width;
            mem_jmp_q    <= ex_jmp;
            mem_br_q     <= ex_br;
            mem_br_inv_q <= ex_br_inv;
            wb_reg_q     <= ex_reg;
        end
    end

    assign mem_valid  = mem_valid_q;
    assign mem_pc     = mem_pc_q;
    assign mem_data0  = mem_data0_q;
    assign mem_data1  = mem_data1_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_extend = mem_extend_q;
    assign mem_width  = mem_width_q;
    assign mem_jmp    = mem_jmp_q;
    assign mem_br     = mem_br_q;
    assign mem_br_inv = mem_br_inv_q;
    assign wb_reg     = wb_reg_q;

endmodule

// File: tb/tb_stage_exec.sv
// Bench for stage_exec: a spec-level reference model checked every cycle plus
// directed vectors with hand-computed expectations.
module tb_stage_exec;

    localparam logic [31:0] RPC = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic        ex_op1_pc, ex_op2_imm;
    logic [3:0]  ex_alu_op;
    logic        ex_read, ex_write, ex_extend;
    logic [1:0]  ex_width;
    logic        ex_jmp, ex_jalr, ex_br, ex_br_inv;
    logic [4:0]  ex_reg;
    logic        ex_flush, mem_stall;

    logic        ex_stall, mem_valid;
    logic [31:0] mem_pc, mem_data0, mem_data1;
    logic        mem_read, mem_write, mem_extend;
    logic [1:0]  mem_width;
    logic        mem_jmp, mem_br, mem_br_inv;
    logic [4:0]  wb_reg;

    int tests = 0;
    int fails = 0;

    stage_exec #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_imm(ex_imm), .ex_op1_pc(ex_op1_pc), .ex_op2_imm(ex_op2_imm),
        .ex_alu_op(ex_alu_op), .ex_read(ex_read), .ex_write(ex_write),
        .ex_extend(ex_extend), .ex_width(ex_width), .ex_jmp(ex_jmp),
        .ex_jalr(ex_jalr), .ex_br(ex_br), .ex_br_inv(ex_br_inv),
        .ex_reg(ex_reg), .ex_flush(ex_flush), .mem_stall(mem_stall),
        .ex_stall(ex_stall), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_data0(mem_data0), .mem_data1(mem_data1), .mem_read(mem_read),
        .mem_write(mem_write), .mem_extend(mem_extend), .mem_width(mem_width),
        .mem_jmp(mem_jmp), .mem_br(mem_br), .mem_br_inv(mem_br_inv),
        .wb_reg(wb_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the ALU written from the operation table.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned n;
        logic [63:0] ext;
        n = b[4:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + (~b) + 32'd1;
            4'd2:  return a * (32'd1 << n);
            4'd3:  return ((a[31] != b[31]) ? a[31] : (a < b)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a / (32'd1 << n);
            4'd7:  begin ext = {{32{a[31]}}, a}; ext = ext >> n; return ext[31:0]; end
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return (a == b) ? 32'd1 : 32'd0;
            default: return b;
        endcase
    endfunction

    logic        m_ok = 1'b0;
    logic        m_valid;
    logic [31:0] m_pc, m_d0, m_d1;
    logic [11:0] m_ctl;

    always @(posedge clk) begin
        logic [31:0] a, b, t;
        a = ex_op1_pc ? ex_pc : ex_op1;
        b = ex_op2_imm ? ex_imm : ex_op2;
        t = (ex_jmp && ex_jalr) ? ((ex_op1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
        m_ok <= 1'b1;
        if (!reset_n) begin
            m_valid <= 1'b0; m_pc <= RPC; m_d0 <= '0; m_d1 <= '0; m_ctl <= '0;
        end else if (!mem_stall) begin
            m_valid <= ex_valid && !ex_flush;
            m_pc    <= ex_pc;
            m_d0    <= ex_jmp ? ex_pc + 32'd4 : ref_alu(ex_alu_op, a, b);
            m_d1    <= (ex_jmp || ex_br) ? t : ex_op2;
            m_ctl   <= {ex_read, ex_write, ex_extend, ex_width, ex_jmp, ex_br, ex_br_inv, ex_reg[3:0]};
        end
    end

    logic [4:0] m_reg;
    always @(posedge clk) begin
        if (!reset_n) m_reg <= '0;
        else if (!mem_stall) m_reg <= ex_reg;
    end

    always @(negedge clk) begin
        #1;
        if (m_ok) begin
            chk("ex_stall", {31'd0, ex_stall}, {31'd0, ex_valid & mem_stall});
            chk("mdl_valid", {31'd0, mem_valid}, {31'd0, m_valid});
            chk("mdl_pc", mem_pc, m_pc);
            chk("mdl_data0", mem_data0, m_d0);
            chk("mdl_data1", mem_data1, m_d1);
            chk("mdl_ctl", {20'd0, mem_read, mem_write, mem_extend, mem_width, mem_jmp,
                            mem_br, mem_br_inv, wb_reg[3:0]}, {20'd0, m_ctl});
            chk("mdl_reg", {27'd0, wb_reg}, {27'd0, m_reg});
        end
    end

    task automatic clear_in();
        ex_valid = 0; ex_pc = 0; ex_op1 = 0; ex_op2 = 0; ex_imm = 0;
        ex_op1_pc = 0; ex_op2_imm = 0; ex_alu_op = 0; ex_read = 0; ex_write = 0;
        ex_extend = 0; ex_width = 0; ex_jmp = 0; ex_jalr = 0; ex_br = 0;
        ex_br_inv = 0; ex_reg = 0; ex_flush = 0;
    endtask

    task automatic alu_in(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] b, input logic use_imm, input logic [4:0] rd);
        clear_in();
        ex_valid = 1; ex_alu_op = op; ex_pc = pc; ex_op1 = a; ex_reg = rd;
        ex_op2_imm = use_imm;
        if (use_imm) ex_imm = b; else ex_op2 = b;
    endtask

    initial begin
        reset_n = 0; mem_stall = 0;
        clear_in();
        ex_valid = 1; ex_op1 = 32'h1234;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_data0", mem_data0, 32'd0);
        chk("rst_pc", mem_pc, RPC);
        clear_in();
        #1 chk("rst_ex_stall", {31'd0, ex_stall}, 32'd0);
        reset_n = 1;

        alu_in(4'd0, 32'h10, 32'hFFFF_FFF0, 32'h20, 1'b1, 5'd5);
        @(negedge clk);
        chk("add_data0", mem_data0, 32'h10);
        chk("add_valid", {31'd0, mem_valid}, 32'd1);
        chk("add_reg", {27'd0, wb_reg}, 32'd5);
        alu_in(4'd7, 32'h14, 32'h8000_0000, 32'd4, 1'b1, 5'd6);
        @(negedge clk);
        chk("sra_data0", mem_data0, 32'hF800_0000);
        alu_in(4'd4, 32'h18, 32'd1, 32'hFFFF_FFFF, 1'b0, 5'd7);
        @(negedge clk);
        chk("sltu_data0", mem_data0, 32'h1);
        chk("sltu_data1", mem_data1, 32'hFFFF_FFFF);

        alu_in(4'd10, 32'h100, 32'd5, 32'd5, 1'b0, 5'd0);
        ex_imm = 32'hFFFF_FFF8; ex_br = 1; ex_br_inv = 1;
        @(negedge clk);
        chk("br_cmp", {31'd0, mem_data0[0]}, 32'd1);
        chk("br_tgt", mem_data1, 32'hF8);
        chk("br_flags", {30'd0, mem_br, mem_br_inv}, 32'd3);

        alu_in(4'd0, 32'h200, 32'h1003, 32'd2, 1'b1, 5'd1);
        ex_jmp = 1; ex_jalr = 1;
        @(negedge clk);
        chk("jalr_link", mem_data0, 32'h204);
        chk("jalr_tgt", mem_data1, 32'h1004);
        chk("jalr_jmp", {31'd0, mem_jmp}, 32'd1);
        chk("jalr_reg", {27'd0, wb_reg}, 32'd1);

        // Sweep every ALU code over a few operand pairs (model-checked).
        for (int op = 0; op < 16; op++) begin
            alu_in(op[3:0], 32'h400 + op * 4, 32'h8000_0F0F, 32'h0000_0023, 1'b0, op[4:0]);
            @(negedge clk);
            alu_in(op[3:0], 32'h500, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 5'd3);
            ex_op1_pc = op[0];
            @(negedge clk);
        end
        chk("sweep_last", mem_data0, 32'hFFFF_FFFE);

        // Load accepted, then stalled with a new instruction waiting.
        alu_in(4'd0, 32'h300, 32'h40, 32'd0, 1'b1, 5'd8);
        ex_read = 1; ex_width = 2; ex_extend = 1;
        @(negedge clk);
        chk("ld_addr", mem_data0, 32'h40);
        chk("ld_read", {31'd0, mem_read}, 32'd1);
        alu_in(4'd0, 32'h304, 32'd7, 32'd3, 1'b1, 5'd9);
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ex_stall", {31'd0, ex_stall}, 32'd1);
            @(negedge clk);
            chk("stall_hold_d0", mem_data0, 32'h40);
            chk("stall_hold_pc", mem_pc, 32'h300);
        end
        mem_stall = 0;
        @(negedge clk);
        chk("rel_data0", mem_data0, 32'd10);
        chk("rel_reg", {27'd0, wb_reg}, 32'd9);
        chk("rel_valid", {31'd0, mem_valid}, 32'd1);
        clear_in();
        @(negedge clk);
        chk("no_dup", {31'd0, mem_valid}, 32'd0);

        alu_in(4'd0, 32'h600, 32'd1, 32'd1, 1'b1, 5'd2);
        ex_flush = 1;
        @(negedge clk);
        chk("flush_bubble", {31'd0, mem_valid}, 32'd0);
        alu_in(4'd0, 32'h604, 32'd1, 32'd1, 1'b1, 5'd2);
        @(negedge clk);
        chk("pre_flush_d0", mem_data0, 32'd2);
        alu_in(4'd0, 32'h608, 32'd5, 32'd5, 1'b1, 5'd4);
        ex_flush = 1; mem_stall = 1;
        repeat (2) begin
            @(negedge clk);
            chk("fstall_valid", {31'd0, mem_valid}, 32'd1);
            chk("fstall_pc", mem_pc, 32'h604);
        end
        mem_stall = 0;
        @(negedge clk);
        chk("fstall_bubble", {31'd0, mem_valid}, 32'd0);

        alu_in(4'd0, 32'h700, 32'd1, 32'd1, 1'b1, 5'd2);
        @(negedge clk);
        mem_stall = 1; reset_n = 0;
        @(negedge clk);
        chk("rst_wins_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_wins_pc", mem_pc, RPC);
        reset_n = 1; mem_stall = 0; clear_in();
        @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
